// File: rtl/rate_div_pkg.sv
// Shared types and constants for the multi-rate divider.
package rate_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int unsigned CNT_W_DEF = 29;

endpackage

// File: rtl/rate_div_channel.sv
// One divider channel: IDLE/RUN/DONE state machine, down-counter, shadow and
// active period, registered terminal-count pulse.
// Optional 8-bit pulse counter when RATE_DIV_TICKCNT_EN is defined.
module rate_div_channel
  import rate_div_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we_i,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] cycles_i,
  input  logic             mode_i,
  input  logic             run_en_i,
  output logic             pulse_o,
  output logic             busy_o
`ifdef RATE_DIV_TICKCNT_EN
  , output logic [7:0]     tick_cnt_o
`endif
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             mode_q, mode_d;
  logic             pulse_q, pulse_d;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      mode_q   <= MODE_PERIODIC;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      mode_q   <= mode_d;
      pulse_q  <= pulse_d;
    end
  end

  // Next-state logic; a restarting write is applied last so it overrides
  // any terminal count on the same edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    mode_d   = mode_q;
    pulse_d  = 1'b0;

    if (we_i) begin
      shadow_d = cycles_i;
      mode_d   = mode_i;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = active_q;
        if (run_en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run_en_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          pulse_d = 1'b1;
          if (mode_d == MODE_ONESHOT) begin
            state_d = ST_DONE;
          end else begin
            cnt_d    = shadow_d;
            active_d = shadow_d;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!run_en_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (we_i && restart_i) begin
      active_d = cycles_i;
      cnt_d    = cycles_i;
      pulse_d  = 1'b0;
      state_d  = run_en_i ? ST_RUN : ST_IDLE;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    busy_o  = (state_q == ST_RUN);
    pulse_o = pulse_q;
  end

`ifdef RATE_DIV_TICKCNT_EN
  logic [7:0] tick_q, tick_d;

  // Pulse counter: wraps naturally, cleared by a restarting write
  always_comb begin
    tick_d = tick_q;
    if (we_i && restart_i) tick_d = '0;
    else if (pulse_d)      tick_d = tick_q + 8'd1;
  end

  // Pulse counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tick_q <= '0;
    else          tick_q <= tick_d;
  end

  assign tick_cnt_o = tick_q;
`endif

endmodule

// File: rtl/multi_rate_divider.sv
// N-channel programmable rate divider, periodic or one-shot per channel,
// configured through a single write port.
// Define RATE_DIV_TICKCNT_EN to add the per-channel tick_cnt pulse counters.
module multi_rate_divider
  import rate_div_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_cycles,
  input  logic                cfg_mode,
  input  logic                cfg_restart,
  input  logic [NUM_CH-1:0]   run_en,
  output logic [NUM_CH-1:0]   pulse,
  output logic [NUM_CH-1:0]   busy
`ifdef RATE_DIV_TICKCNT_EN
  , output logic [NUM_CH*8-1:0] tick_cnt
`endif
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;

    // Write decode: out-of-range channel indices match no channel
    always_comb ch_we = cfg_we && (cfg_ch == CH_W'(i));

    rate_div_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clock      (clock),
      .reset_n    (reset_n),
      .we_i       (ch_we),
      .restart_i  (cfg_restart),
      .cycles_i   (cfg_cycles),
      .mode_i     (cfg_mode),
      .run_en_i   (run_en[i]),
      .pulse_o    (pulse[i]),
      .busy_o     (busy[i])
`ifdef RATE_DIV_TICKCNT_EN
      , .tick_cnt_o (tick_cnt[8*i +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed scoreboard bench for multi_rate_divider. Expected pulse vectors are
// queued when stimulus is applied and popped one per clock.
// Tick-counter checks are included when RATE_DIV_TICKCNT_EN is defined.
module tb_multi_rate_divider;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 29;
  localparam int unsigned CH_W   = 3;  // wide enough to address index NUM_CH

  logic              clock = 1'b0;
  logic              reset_n;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_cycles;
  logic              cfg_mode;
  logic              cfg_restart;
  logic [NUM_CH-1:0] run_en;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] busy;
`ifdef RATE_DIV_TICKCNT_EN
  logic [NUM_CH*8-1:0] tick_cnt;
`endif

  multi_rate_divider #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .CH_W   (CH_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_cycles  (cfg_cycles),
    .cfg_mode    (cfg_mode),
    .cfg_restart (cfg_restart),
    .run_en      (run_en),
    .pulse       (pulse),
    .busy        (busy)
`ifdef RATE_DIV_TICKCNT_EN
    , .tick_cnt  (tick_cnt)
`endif
  );

  always #5 clock = ~clock;

  int unsigned       n_err = 0;
  int unsigned       n_chk = 0;
  logic [NUM_CH-1:0] exp_q[$];
  string             tag;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string t, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", t, obs, exp);
    end
  endtask

  task automatic cfg(input int ch, input int p, input logic mode, input logic rs);
    cfg_we      = 1'b1;
    cfg_ch      = CH_W'(ch);
    cfg_cycles  = CNT_W'(p);
    cfg_mode    = mode;
    cfg_restart = rs;
  endtask

  task automatic cfg_off();
    cfg_we      = 1'b0;
    cfg_restart = 1'b0;
  endtask

  // Queue n expected vectors; channel ch pulses at k = first, first+period, ...
  task automatic push_pat(input int ch, input int first, input int period, input int n);
    for (int k = 1; k <= n; k++) begin
      logic [NUM_CH-1:0] v;
      v = '0;
      if (k >= first && ((k - first) % period) == 0) v[ch] = 1'b1;
      exp_q.push_back(v);
    end
  endtask

  // Advance n clocks, comparing the full pulse vector against the queue
  task automatic run_check(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $error("FAIL %s: scoreboard empty, observed=%0h", tag, pulse);
      end else begin
        check(tag, 32'(pulse), 32'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    cfg_we      = 1'b0;
    cfg_ch      = '0;
    cfg_cycles  = '0;
    cfg_mode    = 1'b0;
    cfg_restart = 1'b0;
    run_en      = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_pulse", 32'(pulse), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
`ifdef RATE_DIV_TICKCNT_EN
    check("rst_tick", tick_cnt, 32'h0);
`endif
    @(negedge clock) reset_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'h0);

    // Periodic, P=4 on ch0
    cfg(0, 4, 1'b0, 1'b1);
    tick();
    cfg_off();
    check("t2_cfg_idle_busy", 32'(busy), 32'h0);
    run_en[0] = 1'b1;
    tick();
    check("t2_entry_busy", 32'(busy), 32'h1);
    check("t2_entry_pulse", 32'(pulse), 32'h0);
    tag = "t2_periodic";
    push_pat(0, 5, 5, 15);
    run_check(15);
    run_en[0] = 1'b0;
    tick();
    check("t2_stop_busy", 32'(busy), 32'h0);

    // One-shot, P=2 on ch1, then re-arm by toggling run_en
    cfg(1, 2, 1'b1, 1'b1);
    tick();
    cfg_off();
    run_en[1] = 1'b1;
    tick();
    check("t3_entry_busy", 32'(busy), 32'h2);
    tag = "t3_oneshot";
    push_pat(1, 3, 100, 8);
    run_check(8);
    check("t3_done_busy", 32'(busy), 32'h0);
    run_en[1] = 1'b0;
    tick();
    run_en[1] = 1'b1;
    tick();
    check("t3_rearm_busy", 32'(busy), 32'h2);
    tag = "t3_rearm";
    push_pat(1, 3, 100, 6);
    run_check(6);
    check("t3_rearm_done_busy", 32'(busy), 32'h0);
    run_en[1] = 1'b0;
    tick();

    // P=0 periodic on ch2
    cfg(2, 0, 1'b0, 1'b1);
    tick();
    cfg_off();
    run_en[2] = 1'b1;
    tick();
    check("t4_entry_pulse", 32'(pulse), 32'h0);
    check("t4_entry_busy", 32'(busy), 32'h4);
    tag = "t4_p0";
    push_pat(2, 1, 1, 6);
    run_check(6);
    run_en[2] = 1'b0;
    tick();
    check("t4_stop_pulse", 32'(pulse), 32'h0);
    check("t4_stop_busy", 32'(busy), 32'h0);

    // Asynchronous reset mid-RUN, between clock edges
    run_en[2] = 1'b1;
    tick();
    tick();
    check("t1_pre_reset_pulse", 32'(pulse), 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_async_pulse", 32'(pulse), 32'h0);
    check("t1_async_busy", 32'(busy), 32'h0);
    run_en = '0;
    #1;
    reset_n = 1'b1;
    tick();
    check("t1_after_busy", 32'(busy), 32'h0);
    check("t1_after_pulse", 32'(pulse), 32'h0);
    // ch0 had P=4 before reset; a cleared active period runs as P=0
    run_en[0] = 1'b1;
    tick();
    tag = "t1_period_cleared";
    push_pat(0, 1, 1, 3);
    run_check(3);
    run_en[0] = 1'b0;
    tick();

    // Shadow write vs restart on ch0, P=9
    cfg(0, 9, 1'b0, 1'b1);
    tick();
    cfg_off();
    run_en[0] = 1'b1;
    tick();
    tag = "t5_old_sched";
    push_pat(0, 99, 99, 4);
    run_check(4);
    cfg(0, 3, 1'b0, 1'b0);
    push_pat(0, 99, 99, 1);
    run_check(1);
    cfg_off();
    tag = "t5_shadow";
    push_pat(0, 5, 4, 15);
    run_check(15);
    tag = "t5_pre_restart";
    push_pat(0, 99, 99, 1);
    run_check(1);
    cfg(0, 3, 1'b0, 1'b1);
    tag = "t5_restart";
    push_pat(0, 5, 4, 9);
    run_check(1);
    cfg_off();
`ifdef RATE_DIV_TICKCNT_EN
    check("t5_tick_cleared", 32'(tick_cnt[7:0]), 32'h0);
`endif
    run_check(1);
    cfg(NUM_CH, 5, 1'b1, 1'b1);
    tag = "t5_bad_ch";
    run_check(1);
    cfg_off();
    run_check(6);
`ifdef RATE_DIV_TICKCNT_EN
    check("t5_tick_count", 32'(tick_cnt[7:0]), 32'h2);
`endif
    run_en[0] = 1'b0;
    tick();

`ifdef RATE_DIV_TICKCNT_EN
    // 256 pulses on ch3 wrap its counter
    cfg(3, 0, 1'b0, 1'b1);
    tick();
    cfg_off();
    check("t6_tick_start", 32'(tick_cnt[31:24]), 32'h0);
    run_en[3] = 1'b1;
    tick();
    tag = "t6_wrap";
    push_pat(3, 1, 1, 255);
    run_check(255);
    check("t6_tick_255", 32'(tick_cnt[31:24]), 32'hFF);
    push_pat(3, 1, 1, 1);
    run_check(1);
    check("t6_tick_wrap", 32'(tick_cnt[31:24]), 32'h0);
    run_en[3] = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
